// File: rtl/dcache_miss_arbiter_pkg.sv
// Shared types for the dcache miss arbiter and the dcache banks that feed it.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELAY
    } channel_state_t;

    localparam int DCACHE_CONSUMERS = 8;
    localparam int CONSUMER_ID_BITS = $clog2(DCACHE_CONSUMERS);

endpackage

// File: rtl/dcache_miss_arbiter_rr_picker.sv
// One-hot pick of the first requester at or after ptr (wrapping), ignoring masked bits.
module rr_picker #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx] && !mask[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_miss_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS dcache miss requesters,
// one transaction FSM per channel, idle channels granted round-robin.
module dcache_miss_arbiter
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = DCACHE_CONSUMERS,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  req_valid,
    input  logic [NUM_CONSUMERS-1:0]                  req_write,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   req_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   req_data,
    output logic [NUM_CONSUMERS-1:0]                  req_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   req_rdata,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);

    localparam int ID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    channel_state_t                                state_q [NUM_CHANNELS];
    channel_state_t                                state_d [NUM_CHANNELS];
    logic [ID_W-1:0]                               owner_q [NUM_CHANNELS];
    logic [ID_W-1:0]                               owner_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]        addr_q, addr_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]        wdata_q, wdata_d;
    logic [NUM_CONSUMERS-1:0]                      ready_q, ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]       rdata_q, rdata_d;
    logic [ID_W-1:0]                               rr_ptr_q, rr_ptr_d;
    logic [NUM_CONSUMERS-1:0]                      owned, eligible;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]    pick_gnt;

    // A consumer stays owned through RELAY, so it cannot be re-granted on its release edge.
    always_comb begin
        owned = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] != IDLE) owned[owner_q[c]] = 1'b1;
        end
        eligible = req_valid & ~owned & ~ready_q;
    end

    // Each channel masks out what lower-indexed channels picked this cycle.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic [NUM_CONSUMERS-1:0] taken_in, taken_out, cand, gnt;
        if (c == 0) begin : g_first
            assign taken_in = '0;
        end else begin : g_next
            assign taken_in = g_chan[c-1].taken_out;
        end
        assign cand = (state_q[c] == IDLE) ? eligible : '0;
        rr_picker #(.N(NUM_CONSUMERS), .IDW(ID_W)) u_pick (
            .req  (cand),
            .mask (taken_in),
            .ptr  (rr_ptr_q),
            .gnt  (gnt)
        );
        assign taken_out   = taken_in | gnt;
        assign pick_gnt[c] = gnt;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ready_d  = ready_q;
        rdata_d  = rdata_q;
        rr_ptr_d = rr_ptr_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                IDLE: begin
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (pick_gnt[c][i]) begin
                            owner_d[c] = ID_W'(i);
                            addr_d[c]  = req_address[i];
                            wdata_d[c] = req_data[i];
                            state_d[c] = req_write[i] ? WRITE_WAIT : READ_WAIT;
                            rr_ptr_d   = (i == NUM_CONSUMERS - 1) ? '0 : ID_W'(i + 1);
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        rdata_d[owner_q[c]] = mem_read_data[c];
                        ready_d[owner_q[c]] = 1'b1;
                        state_d[c]          = RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        ready_d[owner_q[c]] = 1'b1;
                        state_d[c]          = RELAY;
                    end
                end
                RELAY: begin
                    if (!req_valid[owner_q[c]]) begin
                        ready_d[owner_q[c]] = 1'b0;
                        state_d[c]          = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
                owner_q[c] <= '0;
            end
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= '0;
            rdata_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem_read_valid[c]    = (state_q[c] == READ_WAIT);
            mem_write_valid[c]   = (state_q[c] == WRITE_WAIT);
            mem_read_address[c]  = addr_q[c];
            mem_write_address[c] = addr_q[c];
            mem_write_data[c]    = wdata_q[c];
        end
    end

    assign req_ready = ready_q;
    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_dcache_miss_arbiter.sv
// Scoreboarded directed bench for dcache_miss_arbiter; memory returns addr ^ 'h5A on reads.
module tb_dcache_miss_arbiter;

    localparam int NC  = 8;
    localparam int NCH = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NC-1:0]             req_valid = '0, req_write = '0;
    logic [NC-1:0][7:0]        req_address = '0, req_data = '0;
    logic [NC-1:0]             req_ready;
    logic [NC-1:0][7:0]        req_rdata;
    logic [NCH-1:0]            mem_read_valid, mem_write_valid;
    logic [NCH-1:0][7:0]       mem_read_address, mem_write_address, mem_write_data;
    logic [NCH-1:0]            mem_read_ready = '0, mem_write_ready = '0;
    logic [NCH-1:0][7:0]       mem_read_data;

    dcache_miss_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_address(req_address), .req_data(req_data),
        .req_ready(req_ready), .req_rdata(req_rdata),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
    );

    always #5 clk = ~clk;

    typedef struct { int cid; logic [7:0] rdata; } rsp_t;
    typedef struct { int ch; bit wr; logic [7:0] addr; logic [7:0] data; } mem_t;

    rsp_t          rsp_q[$];
    mem_t          mem_q[$];
    int            checks = 0, failures = 0, cyc = 0, n_done = 0;
    logic [7:0]    exp_rdata [NC];
    bit [NC-1:0]   auto_release = '1, dropped_prev = '0;
    int            rereq_left [NC];
    int            rereq_ch [NC];
    bit [NCH-1:0]  ack_en = '1;
    int            ack_delay = 0;
    bit            spur_wr = 1'b0;
    int            rd_cnt [NCH];
    int            wr_cnt [NCH];
    logic [NC-1:0] prev_ready = '0;
    logic [NCH-1:0] prev_rv = '0, prev_wv = '0;
    int            mk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{req_ready, req_rdata, mem_read_valid, mem_read_address,
                 mem_write_valid, mem_write_address, mem_write_data};
    endfunction

    task automatic push_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d, input int ch);
        mem_t m;
        rsp_t r;
        m.ch = ch; m.wr = wr; m.addr = a; m.data = wr ? d : 8'h00;
        mem_q.push_back(m);
        if (!wr) exp_rdata[i] = a ^ 8'h5A;
        r.cid = i; r.rdata = exp_rdata[i];
        rsp_q.push_back(r);
    endtask

    task automatic issue(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d, input int ch);
        req_valid[i] = 1'b1; req_write[i] = wr; req_address[i] = a; req_data[i] = d;
        push_req(i, wr, a, d, ch);
    endtask

    // Consumers drop req_valid once they see req_ready, and optionally re-request a cycle later.
    task automatic tick();
        bit [NC-1:0] dropped_now;
        @(posedge clk);
        #1;
        cyc++;
        dropped_now = '0;
        for (int i = 0; i < NC; i++) begin
            if (dropped_prev[i] && rereq_left[i] > 0) begin
                rereq_left[i]--;
                req_valid[i] = 1'b1;
                push_req(i, req_write[i], req_address[i], req_data[i], rereq_ch[i]);
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (auto_release[i] && req_valid[i] && req_ready[i]) begin
                req_valid[i]   = 1'b0;
                dropped_now[i] = 1'b1;
            end
        end
        dropped_prev = dropped_now;
    endtask

    task automatic clear_bench();
        req_valid = '0; req_write = '0; req_address = '0; req_data = '0;
        rsp_q.delete(); mem_q.delete();
        dropped_prev = '0;
        for (int i = 0; i < NC; i++) begin
            exp_rdata[i] = 8'h00; rereq_left[i] = 0; rereq_ch[i] = 0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_bench();
        tick(); tick();
        reset = 1'b1;
    endtask

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) mem_read_data[ch] = mem_read_address[ch] ^ 8'h5A;
    end

    // Memory responder: ack after ack_delay cycles of valid; spur_wr acks writes regardless of state.
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            mem_read_ready[ch]  = ack_en[ch] && mem_read_valid[ch] && rd_cnt[ch] >= ack_delay;
            mem_write_ready[ch] = (ack_en[ch] && mem_write_valid[ch] && wr_cnt[ch] >= ack_delay) || spur_wr;
            rd_cnt[ch] = mem_read_valid[ch]  ? rd_cnt[ch] + 1 : 0;
            wr_cnt[ch] = mem_write_valid[ch] ? wr_cnt[ch] + 1 : 0;
        end
    end

    task automatic mem_check(input int ch, input bit wr, input logic [7:0] a, input logic [7:0] d);
        mem_t m;
        if (mem_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mem_unexpected: ch%0d wr=%0d addr 0x%0h with none pending", ch, wr, a);
        end else begin
            m = mem_q.pop_front();
            chk($sformatf("mem_req_ch%0d", ch), {8'(ch), 7'd0, wr, a, d},
                {8'(m.ch), 7'd0, m.wr, m.addr, m.data});
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (req_ready[i] && !prev_ready[i]) begin
                mk = -1;
                for (int j = 0; j < rsp_q.size(); j++) if (mk < 0 && rsp_q[j].cid == i) mk = j;
                if (mk < 0) begin
                    checks++; failures++;
                    $display("FAIL rsp_unexpected: consumer %0d ready with no pending request", i);
                end else begin
                    chk($sformatf("rdata_c%0d", i), 32'(req_rdata[i]), 32'(rsp_q[mk].rdata));
                    rsp_q.delete(mk);
                    n_done++;
                end
            end
        end
        prev_ready = req_ready;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mem_read_valid[ch] && !prev_rv[ch]) mem_check(ch, 1'b0, mem_read_address[ch], 8'h00);
            if (mem_write_valid[ch] && !prev_wv[ch])
                mem_check(ch, 1'b1, mem_write_address[ch], mem_write_data[ch]);
        end
        prev_rv = mem_read_valid;
        prev_wv = mem_write_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n0, pulses, pcyc;
        for (int ch = 0; ch < NCH; ch++) begin rd_cnt[ch] = 0; wr_cnt[ch] = 0; end
        clear_bench();
        tick();
        chk("reset_outputs_zero", 32'(any_out()), 0);
        tick();
        reset = 1'b1;

        // 1: single read, held req_ready until the consumer drops req_valid
        apply_reset();
        auto_release[0] = 1'b0;
        issue(0, 1'b0, 8'hFF, 8'h00, 0);
        tick();
        chk("t1_rd_valid", 32'(mem_read_valid), 32'h1);
        chk("t1_rd_addr", 32'(mem_read_address[0]), 32'hFF);
        tick();
        chk("t1_ready", 32'(req_ready), 32'h01);
        chk("t1_rdata", 32'(req_rdata[0]), 32'hA5);
        chk("t1_rd_valid_drop", 32'(mem_read_valid), 32'h0);
        tick(); tick(); tick();
        chk("t1_ready_held", 32'(req_ready), 32'h01);
        req_valid[0] = 1'b0;
        tick();
        chk("t1_ready_release", 32'(req_ready), 32'h00);
        auto_release[0] = 1'b1;

        // 2: read and write on both channels in the same cycle
        apply_reset();
        issue(0, 1'b0, 8'hFF, 8'h00, 0);
        issue(1, 1'b1, 8'hF0, 8'hF0, 1);
        tick();
        chk("t2_rd_valid", 32'(mem_read_valid), 32'h1);
        chk("t2_wr_valid", 32'(mem_write_valid), 32'h2);
        chk("t2_wr_addr_data", {16'd0, mem_write_address[1], mem_write_data[1]}, 32'hF0F0);
        tick();
        chk("t2_ready", 32'(req_ready), 32'h03);
        tick(); tick();

        // 3: four readers, two channels
        apply_reset();
        base = n_done;
        for (int i = 0; i < 4; i++) issue(i, 1'b0, 8'(8'h10 + i), 8'h00, i % 2);
        tick();
        chk("t3_first_valid", 32'(mem_read_valid), 32'h3);
        tick();
        chk("t3_first_ready", 32'(req_ready), 32'h03);
        tick();
        chk("t3_relay_gap", 32'(mem_read_valid), 32'h0);
        tick();
        chk("t3_second_addr", {16'd0, mem_read_address[0], mem_read_address[1]}, 32'h1213);
        for (int k = 0; k < 4; k++) tick();
        chk("t3_done", 32'(n_done - base), 32'd4);

        // 5: consumer drops during READ_WAIT; stray write acks must be ignored
        apply_reset();
        ack_delay = 3;
        issue(2, 1'b0, 8'h2C, 8'h00, 0);
        n0 = cyc; pulses = 0; pcyc = 0;
        spur_wr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cyc == n0 + 2) req_valid[2] = 1'b0;
            if (req_ready[2]) begin pulses++; pcyc = cyc; end
        end
        spur_wr = 1'b0;
        ack_delay = 0;
        chk("t5_pulse_count", 32'(pulses), 32'd1);
        chk("t5_pulse_cycle", 32'(pcyc - n0), 32'd5);
        chk("t5_idle_after", 32'(mem_read_valid), 32'h0);

        // 4: c5 parks ch0 in WRITE_WAIT; c7 and c0 then alternate on ch1
        apply_reset();
        base = n_done;
        ack_en[0] = 1'b0;
        issue(5, 1'b1, 8'h55, 8'hAA, 0);
        tick();
        rereq_left[7] = 1; rereq_ch[7] = 1;
        rereq_left[0] = 1; rereq_ch[0] = 1;
        issue(7, 1'b0, 8'h77, 8'h00, 1);
        issue(0, 1'b0, 8'h00, 8'h00, 1);
        for (int k = 0; k < 20; k++) tick();
        chk("t4_done", 32'(n_done - base), 32'd4);
        chk("t4_mem_q_drained", 32'(mem_q.size()), 32'd0);

        // 6: asynchronous reset while ch0 is still in WRITE_WAIT
        chk("t6_pre_wr_valid", 32'(mem_write_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_zero", 32'(any_out()), 0);
        clear_bench();
        ack_en = '1;
        tick(); tick();
        reset = 1'b1;
        issue(3, 1'b1, 8'h3C, 8'hC3, 0);
        tick();
        chk("t6_wr_valid", 32'(mem_write_valid), 32'h1);
        chk("t6_wr_addr_data", {16'd0, mem_write_address[0], mem_write_data[0]}, 32'h3CC3);
        for (int k = 0; k < 4; k++) tick();

        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
